i2c_arbiter: RTL

Shares one physical open-drain I2C bus among `CLIENT_COUNT` I2C masters, such as device-configuration blocks for the retimer and HDMI redriver. Each client raises `i2c_request` and drives the bus only while its `i2c_grant` is high. The arbiter grants in round-robin order and multiplexes the granted client's SCL/SDA drive onto the pad. Between owners it enforces a bus-free interval so that one client's STOP is never overlapped by the next client's START.

---
 rtl/i2c_arbiter_pkg.sv | 21 ++
 rtl/i2c_arbiter_round_robin_select.sv | 40 ++++
 rtl/i2c_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/i2c_arbiter_pkg.sv
// Shared definitions for the I2C bus arbiter: FSM state encoding and the
// bus-free (5 us) interval derivation, also reused by I2CMaster.
package i2c_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_t;

  // 1 / 5 us, expressed as a rate so the cycle count is a single division.
  localparam int unsigned BUS_FREE_RATE_HZ = 200_000;

  // Clock cycles that make up the bus-free interval, never less than one.
  function automatic int unsigned bus_free_cycles(input int unsigned clock_hz);
    int unsigned cycles;
    cycles = clock_hz / BUS_FREE_RATE_HZ;
    return (cycles < 1) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/i2c_arbiter_round_robin_select.sv
// Combinational round-robin pick: first set request bit at or above the
// pointer, wrapping at CLIENT_COUNT. Returns a one-hot choice and an any flag.
module round_robin_select #(
  parameter int unsigned CLIENT_COUNT  = 4,
  parameter int unsigned POINTER_WIDTH = 2
) (
  input  logic [CLIENT_COUNT-1:0]  i_request,
  input  logic [POINTER_WIDTH-1:0] i_pointer,
  output logic [CLIENT_COUNT-1:0]  o_onehot,
  output logic                     o_any
);

  localparam logic [POINTER_WIDTH:0] N_W = (POINTER_WIDTH+1)'(CLIENT_COUNT);

  logic [POINTER_WIDTH:0]   w_sum;
  logic [POINTER_WIDTH-1:0] w_idx;
  logic                     w_found;

  // Walk the clients starting at the pointer; the first requester wins.
  always_comb begin
    o_onehot = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < CLIENT_COUNT; i++) begin
      w_sum = {1'b0, i_pointer} + (POINTER_WIDTH+1)'(i);
      if (w_sum >= N_W) begin
        w_sum = w_sum - N_W;
      end
      w_idx = w_sum[POINTER_WIDTH-1:0];
      if (!w_found && i_request[w_idx]) begin
        o_onehot[w_idx] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

  assign o_any = w_found;

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one open-drain I2C bus among several masters.
// Grants are registered; the granted client's SCL/SDA drive is muxed onto
// the pads combinationally. A bus-free guard interval separates owners.
module i2c_arbiter
  import i2c_arbiter_pkg::*;
#(
  parameter int unsigned CLIENT_COUNT    = 4,
  parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
  parameter int unsigned BUS_FREE_CYCLES = bus_free_cycles(CLOCK_FREQUENCY)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [CLIENT_COUNT-1:0] request,
  output logic [CLIENT_COUNT-1:0] grant,
  input  logic [CLIENT_COUNT-1:0] client_scl_output,
  input  logic [CLIENT_COUNT-1:0] client_sda_output,
  input  logic                    scl_input,
  input  logic                    sda_input,
  output logic                    scl_output,
  output logic                    sda_output,
  output logic                    busy
);

  localparam int unsigned CW = $clog2(BUS_FREE_CYCLES + 1);
  localparam int unsigned PW = (CLIENT_COUNT > 1) ? $clog2(CLIENT_COUNT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(BUS_FREE_CYCLES - 1);

  arb_state_t              r_state;
  arb_state_t              w_state_next;
  logic [CLIENT_COUNT-1:0] r_grant;
  logic [CLIENT_COUNT-1:0] w_grant_next;
  logic [PW-1:0]           r_pointer;
  logic [PW-1:0]           w_pointer_next;
  logic [CW-1:0]           r_count;
  logic [CW-1:0]           w_count_next;

  logic [CLIENT_COUNT-1:0] w_select;
  logic                    w_select_any;
  logic [PW-1:0]           w_after_owner;
  logic                    w_owner_requesting;

  round_robin_select #(
    .CLIENT_COUNT (CLIENT_COUNT),
    .POINTER_WIDTH(PW)
  ) u_select (
    .i_request(request),
    .i_pointer(r_pointer),
    .o_onehot (w_select),
    .o_any    (w_select_any)
  );

  // Pointer value just past the current owner, wrapping to client 0.
  always_comb begin
    w_after_owner = '0;
    for (int unsigned i = 0; i < CLIENT_COUNT; i++) begin
      if (r_grant[i]) begin
        w_after_owner = (i == CLIENT_COUNT - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  assign w_owner_requesting = |(request & r_grant);

  // Next-state logic: guard counting, grant selection and owner release.
  always_comb begin
    w_state_next   = r_state;
    w_grant_next   = r_grant;
    w_pointer_next = r_pointer;
    w_count_next   = r_count;
    case (r_state)
      ST_GUARD: begin
        if (scl_input && sda_input) begin
          if (r_count == LAST_COUNT) begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
          end else begin
            w_count_next = r_count + CW'(1);
          end
        end else begin
          w_count_next = '0;
        end
      end
      ST_IDLE: begin
        if (w_select_any) begin
          w_grant_next = w_select;
          w_state_next = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (!w_owner_requesting) begin
          w_grant_next   = '0;
          w_pointer_next = w_after_owner;
          w_count_next   = '0;
          w_state_next   = ST_GUARD;
        end
      end
      default: begin
        w_grant_next = '0;
        w_count_next = '0;
        w_state_next = ST_GUARD;
      end
    endcase
  end

  // State register; reset lands in GUARD so the bus is proven free first.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_GUARD;
      r_grant   <= '0;
      r_pointer <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_pointer <= w_pointer_next;
      r_count   <= w_count_next;
    end
  end

  // Non-owner drives are forced to 1 by ~grant, so with no grant the pads
  // release and with a one-hot grant they follow the owner only.
  assign scl_output = &(client_scl_output | ~r_grant);
  assign sda_output = &(client_sda_output | ~r_grant);

  assign grant = r_grant;
  assign busy  = (r_state != ST_IDLE);

endmodule
